pipe_ctrl_v2: RTL and testbench
===============================

PIPE_CTRL_V2 -- requirements
Module: pipe_ctrl_v2

Interface
REQ-001 SHALL have parameters: REG_AW, default 5, register-address width; ALUCTL_W, default 3, ALU control width; MDU_LAT, default 4, multiply/divide busy cycles, legal range 2..15.
REQ-002 SHALL have a single clock, named clk, and an asynchronous active-low reset, named reset; these are fixed.
REQ-003 Port list, in order:
- clk  in  1  clock.
- reset  in  1  async active-low reset.
- OpD, FunctD  in  6 each  decode-stage opcode and funct fields.
- RsD, RtD, RsE, RtE  in  REG_AW each  source register numbers.
- WriteRegE, WriteRegM, WriteRegW  in  REG_AW each  destination register numbers.
- ConditionD  in  1  branch compare result.
- RegWriteE, RegWriteM, RegWriteW  out  1 each  write-enables per stage.
- MemtoRegE, MemtoRegM, MemtoRegW  out  1 each  load-select per stage.
- MemWriteM  out  1  store enable.
- ALUSrcE, RegDstE  out  1 each  execute-stage muxes.
- ALUControlE  out  ALUCTL_W  ALU operation.
- BranchD, JumpD, PCSrcD  out  1 each  control-flow signals.
- ForwardAD, ForwardBD  out  2 each  decode forwarding select.
- ForwardAE, ForwardBE  out  2 each  execute forwarding select.
- StallF, StallD, FlushE  out  1 each  hazard controls.
- MduStartE  out  1  multiply/divide launch.
- MduBusy  out  1  multiply/divide unit occupied.

Function
REQ-004 Decode SHALL recognise OpD 0x00 (R-type), 0x23 (lw), 0x2B (sw), 0x04 (beq), 0x08 (addi) and 0x02 (j). Any other OpD SHALL decode to all controls 0 (NOP).
REQ-005 ALUControl SHALL use these codes: add 010, sub 110, and 000, or 001, slt 111. R-type funct values 0x20, 0x22, 0x24, 0x25 and 0x2A map to these in that order. An unknown funct SHALL produce 010 with RegWrite=0.
REQ-006 PCSrcD SHALL equal BranchD & ConditionD, combinationally.
REQ-007 The D->E control register SHALL clear synchronously when FlushE=1. The E->M and M->W registers SHALL advance every cycle. Latency D->E->M->W SHALL be 1 cycle per stage.
REQ-008 Execute forwarding (ForwardAE shown; ForwardBE is identical using RtE):
- 10 when RegWriteM and WriteRegM==RsE and RsE!=0.
- else 01 when RegWriteW and WriteRegW==RsE and RsE!=0.
- else 00.
- M SHALL take priority over W.
REQ-009 Decode forwarding (ForwardAD shown; ForwardBD uses RtD):
- 01 when RegWriteM and WriteRegM==RsD and RsD!=0.
- else 10 when RegWriteW and WriteRegW==RsD and RsD!=0.
- else 00.
REQ-010 Load-use stall: MemtoRegE and RegWriteE and WriteRegE!=0 and WriteRegE matches RsD or RtD.
REQ-011 Branch stall: BranchD and either (RegWriteE and WriteRegE!=0 matching RsD/RtD) or (MemtoRegM and WriteRegM!=0 matching RsD/RtD).
REQ-012 Any stall SHALL assert StallF, StallD and FlushE in the same cycle. FlushE SHALL be asserted only by a stall.
REQ-013 MDU: R-type funct 0x18 (mult) or 0x1A (div) SHALL register MduStartE=1 one cycle later, in E.
REQ-014 On MduStartE the busy counter SHALL load MDU_LAT-1 and MduBusy SHALL be 1 for exactly MDU_LAT cycles, counting the MduStartE cycle. The counter SHALL saturate at 0.
REQ-015 MDU stall: mult, div, mfhi (0x10) or mflo (0x12) in D while MduBusy=1, or while a mult/div is in E, SHALL stall under REQ-012. The stall SHALL release in the first cycle MduBusy=0.
REQ-016 Simultaneous stall sources SHALL OR together. A flushed MDU op SHALL NOT raise MduStartE.

Reset
REQ-017 On reset=0, all pipeline registers, the MDU counter and every registered output SHALL go to 0 immediately. StallF, StallD and FlushE SHALL follow their combinational equations.
REQ-018 Reset mid-MDU operation SHALL abort it: MduBusy=0 on the next edge after release.

Configuration
REQ-019 Macro PIPE_CTRL_MDU_EN:
- Defined: REQ-013 to REQ-015 implemented.
- Undefined: mult/div/mfhi/mflo decode as NOP; MduStartE and MduBusy are tied 0; no counter is built.

Structure
REQ-020 Package pipe_ctrl_pkg SHALL hold the opcode and funct constants, the ALUControl codes and the forwarding-select codes.
REQ-021 Forwarding and stall logic SHALL be a combinational sub-module, pipe_hazard. Decode and pipeline registers SHALL reside in pipe_ctrl_v2.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- lw $2 then add $3,$2,$4 -> StallF=StallD=FlushE=1 for exactly 1 cycle, then ForwardAE=01 at the add's execute.
- add $5 then beq $5 -> 1 stall cycle, then ForwardAD=01. With ConditionD=1 -> PCSrcD=1.
- RegWriteM and RegWriteW both writing RsE=7 -> ForwardAE=10. Writes to register 0 -> forwarding stays 00.
- mult then mflo immediately (MDU_LAT=4) -> mflo stalls until MduBusy falls, with exact stall-cycle count checked. Without PIPE_CTRL_MDU_EN -> no stall.
- reset=0 asserted while MduBusy=1 -> all outputs 0 asynchronously. After release, MduBusy=0 and the pipeline runs normally.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcode/funct constants, ALU codes, forwarding selects and the stage control word
package pipe_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWDE_M   = 2'b10;
  localparam logic [1:0] FWDE_W   = 2'b01;
  localparam logic [1:0] FWDD_M   = 2'b01;
  localparam logic [1:0] FWDD_W   = 2'b10;
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_ctl;
  } ctrl_t;
endpackage

// File: rtl/pipe_hazard.sv
// pipe_hazard: combinational forwarding selects and stall/flush generation
// Inputs: D/E source regs, E/M/W destinations and write/load flags, BranchD, MDU stall request.
// Outputs: decode/execute forwarding selects, StallF/StallD/FlushE.
module pipe_hazard
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_d_i,
  input  logic [REG_AW-1:0] rt_d_i,
  input  logic [REG_AW-1:0] rs_e_i,
  input  logic [REG_AW-1:0] rt_e_i,
  input  logic [REG_AW-1:0] wr_e_i,
  input  logic [REG_AW-1:0] wr_m_i,
  input  logic [REG_AW-1:0] wr_w_i,
  input  logic              rw_e_i,
  input  logic              rw_m_i,
  input  logic              rw_w_i,
  input  logic              m2r_e_i,
  input  logic              m2r_m_i,
  input  logic              branch_d_i,
  input  logic              mdu_stall_i,
  output logic [1:0]        fwd_ad_o,
  output logic [1:0]        fwd_bd_o,
  output logic [1:0]        fwd_ae_o,
  output logic [1:0]        fwd_be_o,
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              flush_e_o
);
  function automatic logic [1:0] fwd(input logic [REG_AW-1:0] src, input logic [1:0] sel_m, input logic [1:0] sel_w);
    return (src != '0 && rw_m_i && wr_m_i == src) ? sel_m :
           (src != '0 && rw_w_i && wr_w_i == src) ? sel_w : FWD_NONE;
  endfunction
  logic hit_e, hit_m, load_use, br_stall, stall;
  assign fwd_ae_o  = fwd(rs_e_i, FWDE_M, FWDE_W);
  assign fwd_be_o  = fwd(rt_e_i, FWDE_M, FWDE_W);
  assign fwd_ad_o  = fwd(rs_d_i, FWDD_M, FWDD_W);
  assign fwd_bd_o  = fwd(rt_d_i, FWDD_M, FWDD_W);
  assign hit_e     = rw_e_i && wr_e_i != '0 && (wr_e_i == rs_d_i || wr_e_i == rt_d_i);
  assign hit_m     = m2r_m_i && wr_m_i != '0 && (wr_m_i == rs_d_i || wr_m_i == rt_d_i);
  assign load_use  = m2r_e_i && hit_e;
  assign br_stall  = branch_d_i && (hit_e || hit_m);
  assign stall     = load_use | br_stall | mdu_stall_i;
  assign stall_f_o = stall;
  assign stall_d_o = stall;
  assign flush_e_o = stall;
endmodule

// File: rtl/pipe_ctrl_v2.sv
// pipe_ctrl_v2: pipelined MIPS-style control unit with decode, D/E/M/W control registers and hazard unit
// Ports: decode fields (OpD/FunctD/RsD/RtD/ConditionD), stage register numbers from the datapath,
// per-stage controls, forwarding selects, stall/flush, MDU start/busy.
// Macro PIPE_CTRL_MDU_EN builds the multiply/divide tracking; without it mult/div/mfhi/mflo are NOPs.
module pipe_ctrl_v2
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int ALUCTL_W = 3,
  parameter int MDU_LAT  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          OpD,
  input  logic [5:0]          FunctD,
  input  logic [REG_AW-1:0]   RsD,
  input  logic [REG_AW-1:0]   RtD,
  input  logic [REG_AW-1:0]   RsE,
  input  logic [REG_AW-1:0]   RtE,
  input  logic [REG_AW-1:0]   WriteRegE,
  input  logic [REG_AW-1:0]   WriteRegM,
  input  logic [REG_AW-1:0]   WriteRegW,
  input  logic                ConditionD,
  output logic                RegWriteE,
  output logic                RegWriteM,
  output logic                RegWriteW,
  output logic                MemtoRegE,
  output logic                MemtoRegM,
  output logic                MemtoRegW,
  output logic                MemWriteM,
  output logic                ALUSrcE,
  output logic                RegDstE,
  output logic [ALUCTL_W-1:0] ALUControlE,
  output logic                BranchD,
  output logic                JumpD,
  output logic                PCSrcD,
  output logic [1:0]          ForwardAD,
  output logic [1:0]          ForwardBD,
  output logic [1:0]          ForwardAE,
  output logic [1:0]          ForwardBE,
  output logic                StallF,
  output logic                StallD,
  output logic                FlushE,
  output logic                MduStartE,
  output logic                MduBusy
);
  ctrl_t dec_d, e_d, e_q;
  logic  m_rw_q, m_m2r_q, m_mw_q, w_rw_q, w_m2r_q;
  logic  mdu_stall;
  always_comb begin
    dec_d   = '0;
    BranchD = 1'b0;
    JumpD   = 1'b0;
    case (OpD)
      OP_RTYPE: begin
        dec_d = {5'b00001, ALU_ADD};
        case (FunctD)
          FN_ADD: dec_d.reg_write = 1'b1;
          FN_SUB: {dec_d.reg_write, dec_d.alu_ctl} = {1'b1, ALU_SUB};
          FN_AND: {dec_d.reg_write, dec_d.alu_ctl} = {1'b1, ALU_AND};
          FN_OR:  {dec_d.reg_write, dec_d.alu_ctl} = {1'b1, ALU_OR};
          FN_SLT: {dec_d.reg_write, dec_d.alu_ctl} = {1'b1, ALU_SLT};
`ifdef PIPE_CTRL_MDU_EN
          FN_MFHI, FN_MFLO: dec_d.reg_write = 1'b1;
`else
          FN_MULT, FN_DIV, FN_MFHI, FN_MFLO: dec_d = '0;
`endif
          default: ;
        endcase
      end
      OP_LW:   dec_d = {5'b11010, ALU_ADD};
      OP_SW:   dec_d = {5'b00110, ALU_ADD};
      OP_BEQ:  begin
        dec_d   = {5'b00000, ALU_SUB};
        BranchD = 1'b1;
      end
      OP_ADDI: dec_d = {5'b10010, ALU_ADD};
      OP_J:    JumpD = 1'b1;
      default: ;
    endcase
  end
  assign PCSrcD = BranchD & ConditionD;
  // A stall leaves the instruction in D, so E receives a bubble instead.
  assign e_d = FlushE ? '0 : dec_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q     <= '0;
      m_rw_q  <= 1'b0;
      m_m2r_q <= 1'b0;
      m_mw_q  <= 1'b0;
      w_rw_q  <= 1'b0;
      w_m2r_q <= 1'b0;
    end else begin
      e_q     <= e_d;
      m_rw_q  <= e_q.reg_write;
      m_m2r_q <= e_q.mem_to_reg;
      m_mw_q  <= e_q.mem_write;
      w_rw_q  <= m_rw_q;
      w_m2r_q <= m_m2r_q;
    end
  end
  assign RegWriteE   = e_q.reg_write;
  assign MemtoRegE   = e_q.mem_to_reg;
  assign ALUSrcE     = e_q.alu_src;
  assign RegDstE     = e_q.reg_dst;
  assign ALUControlE = ALUCTL_W'(e_q.alu_ctl);
  assign RegWriteM   = m_rw_q;
  assign MemtoRegM   = m_m2r_q;
  assign MemWriteM   = m_mw_q;
  assign RegWriteW   = w_rw_q;
  assign MemtoRegW   = w_m2r_q;
`ifdef PIPE_CTRL_MDU_EN
  logic       mdu_op_d, mdu_use_d, start_q;
  logic [3:0] cnt_d, cnt_q;
  assign mdu_op_d  = OpD == OP_RTYPE && (FunctD == FN_MULT || FunctD == FN_DIV);
  assign mdu_use_d = mdu_op_d || (OpD == OP_RTYPE && (FunctD == FN_MFHI || FunctD == FN_MFLO));
  // Counter holds remaining busy cycles after the start cycle.
  assign cnt_d = start_q ? 4'(MDU_LAT - 1) : (cnt_q != 4'd0 ? cnt_q - 4'd1 : 4'd0);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      start_q <= mdu_op_d & ~FlushE;
      cnt_q   <= cnt_d;
    end
  end
  assign MduStartE = start_q;
  assign MduBusy   = start_q | (cnt_q != 4'd0);
  assign mdu_stall = mdu_use_d & MduBusy;
`else
  assign MduStartE = 1'b0;
  assign MduBusy   = 1'b0;
  assign mdu_stall = 1'b0;
`endif
  pipe_hazard #(.REG_AW(REG_AW)) u_hazard (
    .rs_d_i      (RsD),
    .rt_d_i      (RtD),
    .rs_e_i      (RsE),
    .rt_e_i      (RtE),
    .wr_e_i      (WriteRegE),
    .wr_m_i      (WriteRegM),
    .wr_w_i      (WriteRegW),
    .rw_e_i      (RegWriteE),
    .rw_m_i      (RegWriteM),
    .rw_w_i      (RegWriteW),
    .m2r_e_i     (MemtoRegE),
    .m2r_m_i     (MemtoRegM),
    .branch_d_i  (BranchD),
    .mdu_stall_i (mdu_stall),
    .fwd_ad_o    (ForwardAD),
    .fwd_bd_o    (ForwardBD),
    .fwd_ae_o    (ForwardAE),
    .fwd_be_o    (ForwardBE),
    .stall_f_o   (StallF),
    .stall_d_o   (StallD),
    .flush_e_o   (FlushE)
  );
endmodule

// File: tb/tb_pipe_ctrl_v2.sv
// tb_pipe_ctrl_v2: directed and random instruction streams checked against an instruction-level pipeline model
module tb_pipe_ctrl_v2;
  localparam int LAT = 4;
`ifdef PIPE_CTRL_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif
  typedef struct packed {
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic rw, m2r, mw, asrc, rdst;
    logic [2:0] alu;
    logic br, jp, mdu, mdu_use;
  } ins_t;
  logic clk = 1'b0, reset = 1'b0;
  logic [5:0] OpD = 6'h3F, FunctD = 6'h00;
  logic [4:0] RsD = '0, RtD = '0, RsE = '0, RtE = '0, WriteRegE = '0, WriteRegM = '0, WriteRegW = '0;
  logic ConditionD = 1'b0;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemtoRegW, MemWriteM, ALUSrcE, RegDstE;
  logic [2:0] ALUControlE;
  logic BranchD, JumpD, PCSrcD, StallF, StallD, FlushE, MduStartE, MduBusy;
  logic [1:0] ForwardAD, ForwardBD, ForwardAE, ForwardBE;
  ins_t e_m = '0, m_m = '0, w_m = '0;
  int cyc = 0, last_start = -1000, vectors = 0, errs = 0, n;
  logic [1:0] obs_fae, obs_fbe, obs_fad;
  logic obs_pcs, obs_busy;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pipe_ctrl_v2 #(.REG_AW(5), .ALUCTL_W(3), .MDU_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .OpD(OpD), .FunctD(FunctD), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW), .ConditionD(ConditionD),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemtoRegW(MemtoRegW), .MemWriteM(MemWriteM),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
    .BranchD(BranchD), .JumpD(JumpD), .PCSrcD(PCSrcD),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .MduStartE(MduStartE), .MduBusy(MduBusy)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic ins_t ins(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    ins_t r = '0;
    bit mdu_fn = fn inside {6'h18, 6'h1A, 6'h10, 6'h12};
    r.op = op; r.fn = fn; r.rs = rs; r.rt = rt; r.rd = rd;
    case (op)
      6'h00: if (MDU || !mdu_fn) begin
        r.rdst = 1'b1;
        r.rw = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h10, 6'h12};
        r.alu = fn == 6'h22 ? 3'b110 : fn == 6'h24 ? 3'b000 : fn == 6'h25 ? 3'b001 : fn == 6'h2A ? 3'b111 : 3'b010;
        r.mdu = MDU && fn inside {6'h18, 6'h1A};
        r.mdu_use = MDU && mdu_fn;
      end
      6'h23: begin r.rw = 1; r.m2r = 1; r.asrc = 1; r.alu = 3'b010; end
      6'h2B: begin r.mw = 1; r.asrc = 1; r.alu = 3'b010; end
      6'h04: begin r.br = 1; r.alu = 3'b110; end
      6'h08: begin r.rw = 1; r.asrc = 1; r.alu = 3'b010; end
      6'h02: r.jp = 1;
      default: ;
    endcase
    return r;
  endfunction
  function automatic logic [4:0] dst(input ins_t i);
    return i.rdst ? i.rd : i.rt;
  endfunction
  function automatic logic [1:0] fwd_e(input logic [4:0] s);
    return (s != 0 && m_m.rw && dst(m_m) == s) ? 2'b10 : (s != 0 && w_m.rw && dst(w_m) == s) ? 2'b01 : 2'b00;
  endfunction
  function automatic logic [1:0] fwd_d(input logic [4:0] s);
    return (s != 0 && m_m.rw && dst(m_m) == s) ? 2'b01 : (s != 0 && w_m.rw && dst(w_m) == s) ? 2'b10 : 2'b00;
  endfunction
  task automatic step(input ins_t d, input logic cond, output logic st);
    logic busy, he, hm;
    OpD = d.op; FunctD = d.fn; RsD = d.rs; RtD = d.rt; ConditionD = cond;
    RsE = e_m.rs; RtE = e_m.rt; WriteRegE = dst(e_m); WriteRegM = dst(m_m); WriteRegW = dst(w_m);
    @(negedge clk);
    if (e_m.mdu) last_start = cyc;
    busy = MDU && (cyc - last_start) < LAT;
    he = e_m.rw && dst(e_m) != 0 && (dst(e_m) == d.rs || dst(e_m) == d.rt);
    hm = m_m.m2r && dst(m_m) != 0 && (dst(m_m) == d.rs || dst(m_m) == d.rt);
    st = (e_m.m2r && he) || (d.br && (he || hm)) || (d.mdu_use && busy);
    check("ctrlE", {RegWriteE, MemtoRegE, ALUSrcE, RegDstE, ALUControlE}, {e_m.rw, e_m.m2r, e_m.asrc, e_m.rdst, e_m.alu});
    check("ctrlMW", {RegWriteM, MemtoRegM, MemWriteM, RegWriteW, MemtoRegW}, {m_m.rw, m_m.m2r, m_m.mw, w_m.rw, w_m.m2r});
    check("ctrlD", {BranchD, JumpD, PCSrcD}, {d.br, d.jp, d.br & cond});
    check("fwd", {ForwardAD, ForwardBD, ForwardAE, ForwardBE}, {fwd_d(d.rs), fwd_d(d.rt), fwd_e(e_m.rs), fwd_e(e_m.rt)});
    check("stall", {StallF, StallD, FlushE}, {3{st}});
    check("mdu", {MduStartE, MduBusy}, {e_m.mdu, busy});
    obs_fae = ForwardAE; obs_fbe = ForwardBE; obs_fad = ForwardAD; obs_pcs = PCSrcD; obs_busy = MduBusy;
    @(posedge clk);
    w_m = m_m; m_m = e_m; e_m = st ? '0 : d;
    #1;
  endtask
  task automatic issue(input ins_t d, input logic cond, output int nst);
    logic s;
    nst = 0;
    for (int k = 0; k < 40; k++) begin
      step(d, cond, s);
      if (!s) break;
      nst++;
    end
    check("issue_hang", 16'(nst >= 40), 16'd0);
  endtask
  task automatic check_regs_zero(input string tag);
    check(tag, {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemtoRegW, MemWriteM, ALUSrcE, RegDstE, ALUControlE, MduStartE, MduBusy}, 16'd0);
  endtask
  initial begin
    ins_t nop, d;
    logic [5:0] ops [8] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F};
    logic [5:0] fns [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h1A, 6'h10, 6'h12, 6'h3F};
    nop = ins(6'h3F, 0, 0, 0, 0);
    #3 check_regs_zero("reset_state");
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1;
    issue(ins(6'h23, 0, 1, 2, 0), 0, n);
    issue(ins(6'h00, 6'h20, 2, 4, 3), 0, n);
    check("lu_stall_cycles", 16'(n), 16'd1);
    issue(nop, 0, n);
    check("lu_fwd_ae", 16'(obs_fae), 16'b01);
    issue(ins(6'h00, 6'h20, 1, 2, 5), 0, n);
    issue(ins(6'h04, 0, 5, 0, 0), 1, n);
    check("br_stall_cycles", 16'(n), 16'd1);
    check("br_fwd_ad", 16'(obs_fad), 16'b01);
    check("br_pcsrc", 16'(obs_pcs), 16'd1);
    issue(ins(6'h08, 0, 1, 7, 0), 0, n);
    issue(ins(6'h00, 6'h20, 1, 2, 7), 0, n);
    issue(ins(6'h00, 6'h20, 7, 0, 9), 0, n);
    issue(nop, 0, n);
    check("fwd_m_prio", 16'(obs_fae), 16'b10);
    issue(ins(6'h08, 0, 1, 0, 0), 0, n);
    issue(ins(6'h00, 6'h20, 1, 2, 0), 0, n);
    issue(ins(6'h00, 6'h20, 0, 0, 9), 0, n);
    issue(nop, 0, n);
    check("fwd_r0", 16'({obs_fae, obs_fbe}), 16'd0);
    issue(ins(6'h00, 6'h18, 1, 2, 0), 0, n);
    issue(ins(6'h00, 6'h12, 0, 0, 8), 0, n);
    check("mdu_stall_cycles", 16'(n), MDU ? 16'(LAT) : 16'd0);
    issue(ins(6'h00, 6'h1A, 1, 2, 0), 0, n);
    #2 check("mdu_busy_pre_rst", 16'(MduBusy), 16'(MDU));
    reset = 1'b0;
    OpD = 6'h3F;
    #1 check_regs_zero("rst_async");
    e_m = '0; m_m = '0; w_m = '0; last_start = -1000;
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1;
    issue(ins(6'h00, 6'h12, 0, 0, 8), 0, n);
    check("post_rst_nostall", 16'(n), 16'd0);
    check("post_rst_busy", 16'(obs_busy), 16'd0);
    for (int i = 0; i < 300; i++) begin
      d = ins(ops[$urandom_range(0, 7)], fns[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      issue(d, 1'($urandom_range(0, 1)), n);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
